// File: rtl/copro_pkg.sv
// Shared types for the GCD/LCM coprocessor dispatch block.
package copro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ZRESP,
        DRAIN
    } copro_state_t;

    localparam logic OP_GCD = 1'b0;
    localparam logic OP_LCM = 1'b1;

    // Default-width view of one request (DATA_W = 8, RD_W = 5).
    localparam int unsigned COPRO_DATA_W = 8;
    localparam int unsigned COPRO_RD_W   = 5;

    typedef struct packed {
        logic                    op;
        logic [COPRO_DATA_W-1:0] a;
        logic [COPRO_DATA_W-1:0] b;
        logic [COPRO_RD_W-1:0]   rd;
    } copro_req_t;

endpackage

// File: rtl/copro_timeout_ctr.sv
// WAIT-state watchdog: counts cycles without Done; expired marks the last
// permitted WAIT cycle (count == TIMEOUT_CYC - 1).
module copro_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

    // Cycle counter: cleared on issue, advanced while waiting, saturates at expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/copro_dispatch.sv
// Core-side initiator for the GCD/LCM coprocessor start/Done interface.
// Optional one-entry result cache enabled by defining COPRO_RESULT_CACHE_EN.
module copro_dispatch
    import copro_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned RD_W        = 5,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [RD_W-1:0]   req_rd,
    output logic              cp_start,
    output logic [DATA_W-1:0] cp_x0,
    output logic [DATA_W-1:0] cp_y0,
    output logic              cp_op,
    input  logic              cp_done,
    input  logic [DATA_W-1:0] cp_result,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              busy
);

    copro_state_t state, next_state;

    logic              op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [RD_W-1:0]   rd_q;

    logic              accept;
    logic              zero_req;
    logic [DATA_W-1:0] zero_data;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_data;

    logic tmr_clear, tmr_en, tmr_expired;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign cp_start  = (state == ISSUE);

    // Operand latches double as the coprocessor operand bus, so they stay
    // stable from ISSUE through WAIT without separate output registers.
    assign cp_x0 = a_q;
    assign cp_y0 = b_q;
    assign cp_op = op_q;

    assign zero_req  = (req_a == '0) || (req_b == '0);
    assign zero_data = (req_op == OP_LCM) ? '0 : req_a + req_b;

`ifdef COPRO_RESULT_CACHE_EN
    logic              c_valid;
    logic              c_op;
    logic [DATA_W-1:0] c_a, c_b, c_res;

    assign cache_hit  = c_valid && (c_op == req_op) && (c_a == req_a) && (c_b == req_b);
    assign cache_data = c_res;

    // Result cache: refreshed from every successful coprocessor writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_valid <= 1'b0;
            c_op    <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_res   <= '0;
        end else if (state == RESP && !wb_err) begin
            c_valid <= 1'b1;
            c_op    <= op_q;
            c_a     <= a_q;
            c_b     <= b_q;
            c_res   <= wb_data;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    copro_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and watchdog control.
    always_comb begin
        next_state = state;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (zero_req || cache_hit) ? ZRESP : ISSUE;
                end
            end
            ISSUE: begin
                tmr_clear  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (cp_done || tmr_expired) begin
                    next_state = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                next_state = cp_done ? DRAIN : IDLE;
            end
            ZRESP: begin
                next_state = IDLE;
            end
            DRAIN: begin
                if (!cp_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch and writeback registers; writeback is loaded on the
    // transition into RESP/ZRESP so the pulse coincides with those states
    // and the data holds afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_err   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
                rd_q <= req_rd;
            end
            if (state == IDLE && next_state == ZRESP) begin
                wb_valid <= 1'b1;
                wb_rd    <= req_rd;
                wb_data  <= cache_hit ? cache_data : zero_data;
                wb_err   <= 1'b0;
            end else if (state == WAIT && next_state == RESP) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= cp_done ? cp_result : '0;
                wb_err   <= !cp_done;
            end
        end
    end

endmodule

// File: doc/copro_dispatch.md
Name: copro_dispatch

Overview:
- Core-side initiator for the GCD/LCM coprocessor start/Done interface.
- Accepts one coprocessor request from the execute stage over a valid/ready handshake and latches the operands.
- Drives the coprocessor start, operand and op inputs, then waits for Done and returns the result as a one-cycle writeback pulse.
- Also handles zero operands, a hung coprocessor and back-pressure to the pipeline.

Parameters:
- DATA_W, 8, operand/result width; matches the coprocessor datapath.
- RD_W, 5, destination register index width.
- TIMEOUT_CYC, 1023, maximum WAIT cycles before the request is aborted; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  1  0 = GCD, 1 = LCM.
- req_a, req_b  in  DATA_W  operands.
- req_rd  in  RD_W  destination register.
- cp_start  out  1  start to coprocessor.
- cp_x0, cp_y0  out  DATA_W  coprocessor operands.
- cp_op  out  1  coprocessor Op.
- cp_done  in  1  coprocessor Done, level.
- cp_result  in  DATA_W  coprocessor result, valid while cp_done = 1.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  RD_W  writeback register.
- wb_data  out  DATA_W  writeback value.
- wb_err  out  1  qualifies wb_valid: request timed out, wb_data = 0.
- busy  out  1  request in flight; used as the pipeline stall.

Behaviour:
- Reset values (reset low, asynchronous): state = IDLE; cp_start, wb_valid, wb_err, busy = 0; cp_x0, cp_y0, cp_op, wb_rd, wb_data and the timeout counter = 0.
- req_ready = (state == IDLE). Accept = req_valid && req_ready. On accept, latch req_op/a/b/rd into op_q/a_q/b_q/rd_q.
- States and transitions:
  - IDLE: on accept, go to ZRESP if a == 0 or b == 0, otherwise go to ISSUE.
  - ISSUE: cp_start = 1 for exactly this cycle; cp_x0/cp_y0/cp_op = a_q/b_q/op_q; clear the timeout counter; go to WAIT.
  - WAIT: cp_x0/cp_y0/cp_op held stable and cp_start = 0.
    - On cp_done = 1: capture cp_result and go to RESP.
    - Otherwise, when the counter reaches TIMEOUT_CYC - 1: go to RESP with the error flag set.
    - Otherwise increment the counter.
  - RESP: wb_valid = 1, wb_rd = rd_q, wb_data = captured result (0 if error), wb_err = error flag. Next state is DRAIN if cp_done = 1, else IDLE.
  - ZRESP: wb_valid = 1 and wb_err = 0; coprocessor not started. wb_data:
    - GCD: a + b (returns the nonzero operand, or 0 if both are 0).
    - LCM: 0.
    - Then go to IDLE.
  - DRAIN: wait for cp_done = 0, then go to IDLE. This guarantees Done from one job is never attributed to the next.
- busy = (state != IDLE).
- wb_valid is high for exactly one cycle per accepted request. wb_rd/wb_data/wb_err hold their last values between pulses.
- Latency, counted from the accept edge:
  - Zero-operand path: wb_valid 1 cycle later.
  - Normal path: cp_start 1 cycle later; if cp_done is first seen high N cycles after cp_start, wb_valid is N+1 cycles after cp_start.
- cp_done high in ISSUE (stale level) is ignored; only WAIT samples it.
- Timeout fires after exactly TIMEOUT_CYC WAIT cycles with cp_done low. The next state is DRAIN if cp_done rises on that same cycle.
- Reset mid-operation aborts immediately: no wb_valid, cp_start low, state IDLE. The coprocessor shares this reset.
- No arithmetic beyond the GCD zero-path add (cannot overflow, since one operand is 0) and the counter, which is sized $clog2(TIMEOUT_CYC+1).

Optional Feature:
- Macro: COPRO_RESULT_CACHE_EN.
- With it defined: one-entry cache {valid, op, a, b, result}, written on every non-error RESP.
  - An accept matching a valid entry goes to ZRESP with wb_data = the cached result, and the coprocessor is not started.
  - Zero-operand requests are never cached.
  - The cache is invalidated on reset.
- Without it: every nonzero request is issued to the coprocessor.

Decomposition:
- Package copro_pkg holds:
  - typedef enum logic [2:0] copro_state_t {IDLE, ISSUE, WAIT, RESP, ZRESP, DRAIN};
  - localparam OP_GCD = 1'b0, OP_LCM = 1'b1;
  - typedef struct copro_req_t {op, a, b, rd}.
- One natural sub-module: copro_timeout_ctr (clear/enable/expired), instantiated once.

Test Plan:
- GCD: req a=12, b=18, op=0, rd=7; model raises cp_done 5 cycles after cp_start with result 6 → one wb_valid with rd=7, data=6, err=0; cp_start seen exactly once.
- LCM: req a=4, b=6, op=1; cp_result=12 → wb_data=12.
- Zero operand: GCD(0,9) → wb_data=9 one cycle after accept, cp_start never asserted. LCM(5,0) → wb_data=0.
- Timeout: TIMEOUT_CYC=16, cp_done stuck low → wb_valid with wb_err=1, data=0 exactly 16 WAIT cycles after cp_start, then IDLE.
- Back-pressure and Done held high: req_valid held high during a job → req_ready=0 and the second request is accepted only after cp_done drops (DRAIN); it gets its own cp_start.
- Reset low during WAIT → all outputs 0 asynchronously, no wb_valid; after release, a new GCD(8,12) completes with wb_data=4.
